// File: rtl/serializer_tx_if.sv
// Parallel-word handshake and serial-stream bundle for serializer_tx.
// data_in moves on a rising edge only when data_valid && data_ready are both high on that edge.
interface serializer_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             word_done;
  logic             state_dbg;

  modport master (
    output data_in, data_valid,
    input  data_ready, ser_out, ser_valid, word_done, state_dbg
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, ser_out, ser_valid, word_done, state_dbg
  );
endinterface

// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter with a one-word holding register so that
// back-to-back words stream without an idle bit between them.
module serializer_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  serializer_tx_if.slave  bus
);
  localparam int              CW      = $clog2(WIDTH);
  localparam int              OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;
  localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hr_q, hr_d;
  logic             hr_full_q, hr_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             data_ready;
  logic             transfer;
  logic             last_bit;
  logic [WIDTH-1:0] sr_shifted;

  // Ready is forced low during reset so nothing can be accepted before release.
  assign data_ready = rst_n && !hr_full_q;
  assign transfer   = bus.data_valid && data_ready;
  assign last_bit   = (cnt_q == LAST);
  assign sr_shifted = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    hr_d      = hr_q;
    hr_full_d = hr_full_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          sr_d    = bus.data_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          sr_d  = sr_shifted;
          cnt_d = cnt_q + CW'(1);
          if (transfer) begin
            hr_d      = bus.data_in;
            hr_full_d = 1'b1;
          end
        end else if (hr_full_q) begin
          sr_d      = hr_q;
          hr_full_d = 1'b0;
          cnt_d     = '0;
        end else if (transfer) begin
          sr_d  = bus.data_in;
          cnt_d = '0;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      hr_q      <= '0;
      hr_full_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      hr_q      <= hr_d;
      hr_full_q <= hr_full_d;
      cnt_q     <= cnt_d;
    end
  end

  // Idle line sits high so a downstream detector never sees a spurious zero.
  assign bus.data_ready = data_ready;
  assign bus.ser_valid  = (state_q == SHIFT);
  assign bus.ser_out    = (state_q == SHIFT) ? sr_q[OUT_IDX] : 1'b1;
  assign bus.word_done  = (state_q == SHIFT) && last_bit;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_serializer_tx.sv
// Directed bench for serializer_tx: one MSB-first and one LSB-first instance,
// hand-computed bit streams, handshake timing and reset behaviour.
module tb_serializer_tx;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serializer_tx_if #(.WIDTH(W)) m_if ();
  serializer_tx_if #(.WIDTH(W)) l_if ();

  serializer_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(m_if.slave));
  serializer_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(l_if.slave));

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] stim_q[$];
  int           stim_at_q[$];
  logic [W-1:0] exp_q[$];
  logic         obs_q[$];
  logic         rdy_hist[$];
  int first_valid, last_valid, n_valid, first_xfer;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m"}, 32'({m_if.ser_out, m_if.ser_valid, m_if.word_done, m_if.data_ready, m_if.state_dbg}), 32'b10000);
    check({tag, "_l"}, 32'({l_if.ser_out, l_if.ser_valid, l_if.word_done, l_if.data_ready, l_if.state_dbg}), 32'b10000);
  endtask

  // Drives queued words on the MSB-first instance and records its serial output.
  task automatic run_m(input int n_cycles);
    logic xfer;
    first_valid = -1; last_valid = -1; n_valid = 0; first_xfer = -1;
    obs_q.delete();
    rdy_hist.delete();
    for (int c = 0; c < n_cycles; c++) begin
      if (stim_q.size() != 0 && c >= stim_at_q[0]) begin
        m_if.data_valid = 1'b1;
        m_if.data_in    = stim_q[0];
      end else begin
        m_if.data_valid = 1'b0;
        m_if.data_in    = W'($urandom_range(0, 255));
      end
      xfer = m_if.data_valid && m_if.data_ready;
      @(posedge clk);
      #1;
      if (xfer) begin
        void'(stim_q.pop_front());
        void'(stim_at_q.pop_front());
        if (first_xfer < 0) first_xfer = c;
      end
      rdy_hist.push_back(m_if.data_ready);
      if (m_if.ser_valid) begin
        check("word_done", 32'(m_if.word_done), 32'((obs_q.size() % W) == W - 1));
        obs_q.push_back(m_if.ser_out);
        if (first_valid < 0) first_valid = c;
        last_valid = c;
        n_valid++;
      end else begin
        check("idle_line", 32'({m_if.ser_out, m_if.word_done}), 32'b10);
      end
    end
    m_if.data_valid = 1'b0;
  endtask

  // Rebuilds MSB-first words from the captured bits and compares with exp_q.
  task automatic verify_stream(input string tag);
    logic [W-1:0] word;
    int nw;
    nw = exp_q.size();
    check({tag, "_nbits"}, 32'(obs_q.size()), 32'(nw * W));
    if (obs_q.size() == nw * W) begin
      for (int k = 0; k < nw; k++) begin
        word = '0;
        for (int i = 0; i < W; i++) word = {word[W-2:0], obs_q[k*W + i]};
        check({tag, "_word"}, 32'(word), 32'(exp_q[k]));
      end
    end
    if (n_valid > 0) check({tag, "_nogap"}, 32'(last_valid - first_valid + 1), 32'(n_valid));
    exp_q.delete();
  endtask

  logic [W-1:0] lsb_word;
  logic [W-1:0] lsb_seq;

  initial begin
    m_if.data_in = '0; m_if.data_valid = 1'b0;
    l_if.data_in = '0; l_if.data_valid = 1'b0;

    // Reset holds outputs with no clock edge yet.
    #2;
    check_reset_outputs("reset_async");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_clocked");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", 32'(m_if.data_ready), 32'd1);

    // Single word 6F, first edge after reset: 0,1,1,0,1,1,1,1 then idle.
    stim_q.push_back(8'h6F); stim_at_q.push_back(0); exp_q.push_back(8'h6F);
    run_m(12);
    check("first_edge_xfer", 32'(first_xfer), 32'd0);
    check("latency1", 32'(first_valid), 32'd0);
    verify_stream("w6f");

    // Idle: nothing emitted, always ready.
    run_m(5);
    check("idle_nvalid", 32'(n_valid), 32'd0);
    for (int c = 0; c < 5; c++) check("idle_ready", 32'(rdy_hist[c]), 32'd1);

    // Sustained valid: A5, 3C, FF stream back to back.
    foreach (stim_q[i]) ;
    stim_q.push_back(8'hA5); stim_at_q.push_back(0); exp_q.push_back(8'hA5);
    stim_q.push_back(8'h3C); stim_at_q.push_back(0); exp_q.push_back(8'h3C);
    stim_q.push_back(8'hFF); stim_at_q.push_back(0); exp_q.push_back(8'hFF);
    run_m(30);
    check("burst_nvalid", 32'(n_valid), 32'd24);
    check("burst_rdy_c1", 32'(rdy_hist[1]), 32'd0);
    check("burst_rdy_c7", 32'(rdy_hist[7]), 32'd0);
    check("burst_rdy_c8", 32'(rdy_hist[8]), 32'd1);
    check("burst_rdy_c9", 32'(rdy_hist[9]), 32'd0);
    check("burst_rdy_c16", 32'(rdy_hist[16]), 32'd1);
    check("burst_left", 32'(stim_q.size()), 32'd0);
    verify_stream("burst");

    // Second word offered exactly on the last-bit edge with HR empty.
    stim_q.push_back(8'h11); stim_at_q.push_back(0); exp_q.push_back(8'h11);
    stim_q.push_back(8'hE7); stim_at_q.push_back(8); exp_q.push_back(8'hE7);
    run_m(20);
    check("lastedge_rdy_c7", 32'(rdy_hist[7]), 32'd1);
    check("lastedge_nvalid", 32'(n_valid), 32'd16);
    verify_stream("lastedge");

    // Reset at bit 4 with HR holding a second word.
    stim_q.push_back(8'hC3); stim_at_q.push_back(0);
    stim_q.push_back(8'h96); stim_at_q.push_back(1);
    run_m(5);
    check("pre_rst_bits", 32'(n_valid), 32'd5);
    check("pre_rst_hrfull", 32'(m_if.data_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_midword");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_m(4);
    check("post_rst_nvalid", 32'(n_valid), 32'd0);
    stim_q.push_back(8'h5A); stim_at_q.push_back(0); exp_q.push_back(8'h5A);
    run_m(12);
    check("post_rst_xfer", 32'(first_xfer), 32'd0);
    verify_stream("post_rst");

    // LSB-first instance: 01 -> 1,0,0,0,0,0,0,0 and B4 -> 0,0,1,0,1,1,0,1.
    for (int t = 0; t < 2; t++) begin
      lsb_word = (t == 0) ? 8'h01 : 8'hB4;
      lsb_seq  = (t == 0) ? 8'b1000_0000 : 8'b0010_1101;
      check("lsb_ready", 32'(l_if.data_ready), 32'd1);
      l_if.data_in    = lsb_word;
      l_if.data_valid = 1'b1;
      @(posedge clk);
      #1;
      l_if.data_valid = 1'b0;
      l_if.data_in    = W'($urandom_range(0, 255));
      for (int i = 0; i < W; i++) begin
        check("lsb_valid", 32'(l_if.ser_valid), 32'd1);
        check("lsb_bit", 32'(l_if.ser_out), 32'(lsb_seq[W-1-i]));
        check("lsb_done", 32'(l_if.word_done), 32'(i == W - 1));
        @(posedge clk);
        #1;
      end
      check("lsb_idle", 32'({l_if.ser_out, l_if.ser_valid}), 32'b10);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/serializer_tx.md
SERIALIZER_TX -- requirements
Module: serializer_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: word width in bits (legal range 2..16).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data_in  input  WIDTH  parallel word to send.
REQ-006 SHALL have port data_valid  input  1  data_in holds a word offered for transfer.
REQ-007 SHALL have port data_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port ser_out  output  1  serial bit stream to the downstream sequence detector's input.
REQ-009 SHALL have port ser_valid  output  1  ser_out carries a data bit this cycle.
REQ-010 SHALL have port word_done  output  1  ser_out carries the last bit of a word this cycle.

Function
REQ-011 SHALL contain a shift register SR (WIDTH bits), a bit counter CNT (0..WIDTH-1), a holding register HR (WIDTH bits) with flag HR_FULL, and a two-state FSM IDLE/SHIFT.
REQ-012 SHALL perform a transfer on a rising edge where data_valid=1 and data_ready=1; no transfer otherwise.
REQ-013 SHALL drive data_ready = !HR_FULL while rst_n=1.
REQ-014 Transfer in IDLE: SHALL load data_in into SR, CNT<=0, FSM->SHIFT; first bit appears on ser_out the cycle after the transfer edge (latency 1).
REQ-015 Transfer in SHIFT with CNT<WIDTH-1: SHALL load data_in into HR, HR_FULL<=1.
REQ-016 In SHIFT, each cycle SHALL present one bit on ser_out with ser_valid=1; each edge with CNT<WIDTH-1 shifts SR one position (per MSB_FIRST) and increments CNT.
REQ-017 word_done SHALL equal ser_valid AND CNT==WIDTH-1.
REQ-018 On the edge ending the last bit (CNT==WIDTH-1): if HR_FULL, SHALL move HR into SR, clear HR_FULL, CNT<=0, stay SHIFT (no gap cycle).
REQ-019 Same edge, HR_FULL=0 and a transfer occurs: SHALL load data_in directly into SR, CNT<=0, stay SHIFT (no gap).
REQ-020 Same edge, HR_FULL=0 and no transfer: SHALL go to IDLE.
REQ-021 In IDLE, SHALL drive ser_out=1 and ser_valid=0 (idle line high, so the downstream detector sees no spurious 0).
REQ-022 SHALL not drop or duplicate words: every transferred word is emitted exactly once, in transfer order, each bit held exactly one cycle.
REQ-023 Changes on data_in/data_valid without a transfer SHALL have no effect.
REQ-024 Sustained data_valid=1 SHALL yield a continuous bitstream with ser_valid never deasserting between words.

Reset
REQ-025 While rst_n=0, SHALL hold FSM=IDLE, CNT=0, SR=0, HR=0, HR_FULL=0, ser_out=1, ser_valid=0, word_done=0, data_ready=0, independent of clk.
REQ-026 Reset asserted mid-word SHALL abandon the word in SR and HR; no bits of it emitted after release.
REQ-027 First rising edge with rst_n=1 SHALL be able to perform a transfer (data_ready=1 once rst_n=1).

Verification
REQ-028 Reset then idle 5 cycles -> ser_out=1, ser_valid=0, data_ready=1, word_done=0 throughout.
REQ-029 MSB_FIRST=1, single transfer data_in=8'h6F -> next 8 cycles ser_out=0,1,1,0,1,1,1,1, ser_valid=1, word_done only on 8th; then IDLE, ser_out=1; chained detector pulses out=1 once.
REQ-030 MSB_FIRST=0, data_in=8'h01 -> ser_out=1,0,0,0,0,0,0,0.
REQ-031 data_valid held 1 with words 8'hA5, 8'h3C, 8'hFF -> 24 consecutive ser_valid cycles, no gap, correct bits; data_ready=0 while HR_FULL=1.
REQ-032 Transfer exactly on the last-bit edge with HR empty -> next word's first bit the following cycle, no gap.
REQ-033 rst_n pulsed low at bit 4 of a word with HR full -> outputs immediately to reset values; after release ser_out=1 until a new transfer; old words never reappear.
